// File: rtl/fetch_sequencer.sv
// Fetch control stage: sequences the PC of an external fetch block, resolves jumps and HALT locally,
// and holds one forwarded instruction in a valid/ready output slot toward decode.
module fetch_sequencer #(
    parameter logic [5:0] OPC_JUMP = 6'h02,
    parameter logic [5:0] OPC_HALT = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instruction,
    output logic        PC_WE,
    output logic        PC_reset,
    output logic        PC_Src,
    output logic [15:0] offset,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_instr_out;
    logic        r_instr_valid;
    logic [15:0] r_issue_count;
    logic        w_slot_free;
    logic        w_issue;
    logic        w_forward;
    logic [5:0]  w_opcode;

    assign w_slot_free = (~r_instr_valid) | instr_ready;
    assign w_opcode    = instruction[31:26];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and fetch-block control decode
    always_comb begin
        w_next_state = r_state;
        PC_WE        = 1'b0;
        PC_reset     = 1'b0;
        PC_Src       = 1'b0;
        offset       = 16'h0000;
        halted       = 1'b0;
        w_issue      = 1'b0;
        w_forward    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_INIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_INIT: begin
                PC_reset     = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                offset = instruction[15:0];
                // A blocked slot freezes the PC; HALT also waits here until the slot frees.
                if (w_slot_free) begin
                    if (w_opcode == OPC_HALT) begin
                        w_next_state = S_HALT;
                    end else if (w_opcode == OPC_JUMP) begin
                        PC_WE   = 1'b1;
                        PC_Src  = 1'b1;
                        w_issue = 1'b1;
                    end else begin
                        PC_WE     = 1'b1;
                        w_issue   = 1'b1;
                        w_forward = 1'b1;
                    end
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    w_next_state = S_INIT;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output slot toward decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_out   <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
        end else if (w_forward) begin
            r_instr_out   <= instruction;
            r_instr_valid <= 1'b1;
        end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= r_instr_valid;
        end
    end

    // Saturating issue counter; survives HALT/restart, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_count <= 16'h0000;
        end else if (w_issue && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'h0001;
        end else begin
            r_issue_count <= r_issue_count;
        end
    end

    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign issue_count = r_issue_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural fetch block feeds programs; forwarded words
// are checked by a monitor against a queue filled by the stimulus process.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] instruction;
    logic        PC_WE;
    logic        PC_reset;
    logic        PC_Src;
    logic [15:0] offset;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        halted;
    logic [15:0] issue_count;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic [31:0] mem [0:15];
    logic [31:0] pc = 32'h0000_0024;
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          mon_checks = 0;
    int          mon_errors = 0;
    int          cyc = 0;
    int          last_xfer = 0;
    int          prev_xfer = 0;
    int          n_pcreset = 0;
    int          snap;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .PC_WE       (PC_WE),
        .PC_reset    (PC_reset),
        .PC_Src      (PC_Src),
        .offset      (offset),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch block model: PC is not touched by rst_n
    assign instruction = mem[pc[5:2]];
    always @(posedge clk) begin
        if (PC_reset) pc <= 32'h0000_0000;
        else if (PC_WE) pc <= PC_Src ? pc + {{14{offset[15]}}, offset, 2'b00} : pc + 32'd4;
        cyc <= cyc + 1;
    end

    // Monitor: pops the scoreboard on every accepted transfer
    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (PC_reset) n_pcreset = n_pcreset + 1;
        if (rst_n && instr_valid && instr_ready) begin
            mon_checks = mon_checks + 1;
            if (exp_q.size() == 0) begin
                mon_errors = mon_errors + 1;
                $display("FAIL xfer_unexpected: got %h, required no transfer", instr_out);
            end else begin
                exp_word = exp_q.pop_front();
                if (instr_out !== exp_word) begin
                    mon_errors = mon_errors + 1;
                    $display("FAIL xfer_word: got %h, required %h", instr_out, exp_word);
                end
            end
            prev_xfer = last_xfer;
            last_xfer = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic load_prog(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        for (int i = 0; i < 16; i++) mem[i] = HALT_W;
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    // Called at #1 after an edge; returns at #1 after the first RUN edge
    task automatic start_prog();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("init_pc_reset", {31'd0, PC_reset}, 32'd1);
        @(posedge clk); #1;
        chk("run_not_halted", {31'd0, halted}, 32'd0);
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        instr_ready = 1'b1;
        load_prog(HALT_W, HALT_W, HALT_W, HALT_W);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, 32'd0);
        chk("rst_count", {16'd0, issue_count}, 32'd0);
        chk("rst_ctrl", {26'd0, PC_WE, PC_reset, PC_Src, halted, 2'b00}, 32'd0);
        chk("rst_offset", {16'd0, offset}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Straight-line program at full throughput
        load_prog(32'h0000_0011, 32'h0000_0022, HALT_W, HALT_W);
        exp_q.push_back(32'h0000_0011);
        exp_q.push_back(32'h0000_0022);
        snap = n_pcreset;
        start_prog();
        wait_halted("t1_halted", 20);
        chk("t1_count", {16'd0, issue_count}, 32'd2);
        chk("t1_pcreset_once", n_pcreset - snap, 32'd1);
        chk("t1_back_to_back", last_xfer - prev_xfer, 32'd1);
        chk("t1_drained", exp_q.size(), 32'd0);
        do_reset();

        // Forward jump skips word 2
        load_prog(32'h0000_0011, 32'h0800_0002, 32'h0000_0099, HALT_W);
        exp_q.push_back(32'h0000_0011);
        start_prog();
        wait_halted("t2_halted", 20);
        chk("t2_count", {16'd0, issue_count}, 32'd2);
        chk("t2_drained", exp_q.size(), 32'd0);
        do_reset();

        // Backward jump loop, then asynchronous reset with a word in the slot
        load_prog(32'h0000_0055, 32'h0800_FFFF, HALT_W, HALT_W);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0055);
        start_prog();
        repeat (9) @(posedge clk);
        #1;
        chk("t3_count", {16'd0, issue_count}, 32'd9);
        chk("t3_valid", {31'd0, instr_valid}, 32'd1);
        chk("t3_out", instr_out, 32'h0000_0055);
        chk("t3_period", last_xfer - prev_xfer, 32'd2);
        chk("t3_drained", exp_q.size(), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_async_count", {16'd0, issue_count}, 32'd0);
        chk("t5_async_out", instr_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-pressure: slot held while decode stalls
        instr_ready = 1'b0;
        load_prog(32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, HALT_W);
        exp_q.push_back(32'h0000_00A1);
        exp_q.push_back(32'h0000_00A2);
        exp_q.push_back(32'h0000_00A3);
        start_prog();
        chk("t4_first_we", {31'd0, PC_WE}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_out", instr_out, 32'h0000_00A1);
            chk("t4_hold_we", {31'd0, PC_WE}, 32'd0);
            @(posedge clk); #1;
        end
        instr_ready = 1'b1;
        wait_halted("t4_halted", 20);
        chk("t4_count", {16'd0, issue_count}, 32'd3);
        chk("t4_drained", exp_q.size(), 32'd0);

        // Restart from HALT keeps the count
        exp_q.push_back(32'h0000_00A1);
        exp_q.push_back(32'h0000_00A2);
        exp_q.push_back(32'h0000_00A3);
        snap = n_pcreset;
        start_prog();
        wait_halted("t6_halted", 20);
        chk("t6_count", {16'd0, issue_count}, 32'd6);
        chk("t6_pcreset_once", n_pcreset - snap, 32'd1);
        chk("t6_drained", exp_q.size(), 32'd0);
        do_reset();

        // Self-loop jump drives the counter into saturation
        load_prog(32'h0800_0000, HALT_W, HALT_W, HALT_W);
        start_prog();
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_fffe", {16'd0, issue_count}, 32'h0000_FFFE);
        chk("sat_jump_ctrl", {30'd0, PC_WE, PC_Src}, 32'd3);
        chk("sat_no_forward", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;
        chk("sat_ffff", {16'd0, issue_count}, 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", {16'd0, issue_count}, 32'h0000_FFFF);

        @(negedge clk);
        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
